// File: rtl/core_pkg.sv
// Shared writeback types: register-file geometry, the writeback request record and
// the producer identifier used by the arbiter.
package core_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 2 ** AW;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests. The head is read from storage only,
// so a pushed entry is visible no earlier than the cycle after the push.
module wb_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);

    localparam int unsigned PW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indices match.
    logic [PW:0] wptr_q;
    logic [PW:0] rptr_q;
    wb_req_t     mem [DEPTH];

    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
        head  = mem[rptr_q[PW-1:0]];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push && !full) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wptr_q[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: round-robin between the ALU and a buffered LSU
// result stream, a registered write port and a per-register pending scoreboard.
module rf_wb_arbiter
    import core_pkg::*;
#(
    parameter int unsigned LSU_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] pending
);

    logic      fifo_full;
    logic      fifo_empty;
    wb_req_t   lsu_in;
    wb_req_t   lsu_head;
    wb_req_t   alu_in;
    wb_req_t   winner;
    wb_src_e   rr_last_q;
    logic      grant_alu;
    logic      grant_lsu;
    logic      grant;
    logic [NREG-1:0] pending_d;

    assign lsu_in.rd   = lsu_rd;
    assign lsu_in.data = lsu_data;
    assign alu_in.rd   = alu_rd;
    assign alu_in.data = alu_data;

    wb_fifo #(
        .DEPTH (LSU_DEPTH)
    ) u_lsu_fifo (
        .clock (clock),
        .reset (reset),
        .push  (lsu_valid && !fifo_full),
        .pop   (grant_lsu),
        .din   (lsu_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (lsu_head)
    );

    always_comb begin
        grant_alu = alu_valid && (fifo_empty || rr_last_q == SRC_LSU);
        grant_lsu = !fifo_empty && (!alu_valid || rr_last_q == SRC_ALU);
        grant     = grant_alu || grant_lsu;
        winner    = grant_alu ? alu_in : lsu_head;
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = !fifo_full;

    // Set after clear: a same-cycle issue to the retiring rd is a newer producer.
    always_comb begin
        pending_d = pending;
        if (grant) begin
            pending_d[winner.rd] = 1'b0;
        end
        if (iss_valid) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_wen    <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            pending   <= '0;
            rr_last_q <= SRC_LSU;
        end else begin
            rf_wen  <= grant && (winner.rd != '0);
            pending <= pending_d;
            if (grant) begin
                rf_waddr  <= winner.rd;
                rf_wdata  <= winner.data;
                rr_last_q <= grant_alu ? SRC_ALU : SRC_LSU;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected register writes are queued as stimulus
// is driven and compared in order as rf_wen pulses appear.
module tb_rf_wb_arbiter;
    import core_pkg::*;

    logic            clock = 1'b0;
    logic            reset;
    logic            alu_valid, lsu_valid, iss_valid;
    logic            alu_ready, lsu_ready;
    logic [AW-1:0]   alu_rd, lsu_rd, iss_rd;
    logic [XLEN-1:0] alu_data, lsu_data;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] pending;

    int      total = 0;
    int      bad   = 0;
    wb_req_t exp_q[$];
    wb_req_t lsu_model[$];
    wb_req_t mon_e;

    rf_wb_arbiter #(
        .LSU_DEPTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pending   (pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Every write pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset === 1'b0 && rf_wen !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("stray_wen", 64'(rf_wen), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("waddr", 64'(rf_waddr), 64'(mon_e.rd));
                chk("wdata", 64'(rf_wdata), 64'(mon_e.data));
            end
        end
    end

    // One cycle: drive inputs, check handshakes, update the expectation queues.
    task automatic cyc(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                       input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ld,
                       input logic iv, input logic [AW-1:0] ird,
                       input logic x_ar, input logic x_lr, input logic x_lg);
        wb_req_t r;
        @(negedge clock);
        alu_valid = av;  alu_rd = ard;  alu_data = ad;
        lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ld;
        iss_valid = iv;  iss_rd = ird;
        #1;
        chk("alu_ready", 64'(alu_ready), 64'(x_ar));
        chk("lsu_ready", 64'(lsu_ready), 64'(x_lr));
        if (x_ar && ard != '0) begin
            r.rd = ard;  r.data = ad;
            exp_q.push_back(r);
        end
        if (x_lg && lsu_model.size() > 0) begin
            r = lsu_model.pop_front();
            if (r.rd != '0) exp_q.push_back(r);
        end
        if (lv && x_lr) begin
            r.rd = lrd;  r.data = ld;
            lsu_model.push_back(r);
        end
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nl;
        logic [AW-1:0] lrd;
        reset = 1'b1;
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 0; iss_rd = '0;
        #1;
        chk("rst_wen", 64'(rf_wen), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // ALU only: accepted at once, written one cycle later.
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle();
        chk("t1_wen", 64'(rf_wen), 64'd1);
        chk("t1_drain", 64'(exp_q.size()), 64'd0);

        // Tie: last grant was ALU, so LSU goes first and then they alternate.
        cyc(1'b0, '0, '0, 1'b1, 5'd2, 32'h22, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        na = 0;  nl = 1;
        for (int k = 0; k < 6; k++) begin
            logic ar;
            ar = (k % 2 == 1);
            cyc(1'b1, 5'd1, 32'h100 + na, (k < 2), 5'd2, 32'h22 + nl, 1'b0, '0,
                ar, 1'b1, !ar);
            if (ar) na++;
            if (k < 2) nl++;
        end
        idle();
        idle();
        chk("t2_drain", 64'(exp_q.size()), 64'd0);

        // FIFO fill under alternating grants: full after the 4th outstanding entry.
        na = 0;  nl = 0;
        for (int c = 0; c < 14; c++) begin
            logic av, lv, ar, lr, lg;
            av  = (c < 10);
            lv  = (c < 10);
            ar  = av && (c % 2 == 0);
            lr  = !(c == 7 || c == 9);
            lg  = (c < 10) ? (c % 2 == 1) : (c < 13);
            lrd = (nl == 2) ? 5'd0 : 5'(8 + nl);
            cyc(av, 5'd3, 32'h300 + na, lv, lrd, 32'hA000 + nl, 1'b0, '0, ar, lr, lg);
            if (ar) na++;
            if (lv && lr) nl++;
        end
        idle();
        chk("t3_drain", 64'(exp_q.size()), 64'd0);
        chk("t3_model", 64'(lsu_model.size()), 64'd0);

        // Write to x0: consumed without a register write.
        cyc(1'b1, 5'd0, 32'h1234, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle();
        chk("t4_wen", 64'(rf_wen), 64'd0);
        chk("t4_pending", 64'(pending), 64'd0);

        // Scoreboard set, same-cycle set/clear, later clear, x0 issue ignored.
        cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
        idle();
        chk("t5_set", 64'(pending), 64'h80);
        cyc(1'b1, 5'd7, 32'h777, 1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
        idle();
        chk("t5_set_wins", 64'(pending), 64'h80);
        chk("t5_wen", 64'(rf_wen), 64'd1);
        cyc(1'b1, 5'd7, 32'h778, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle();
        chk("t5_clear", 64'(pending), 64'd0);
        cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("t5_x0", 64'(pending), 64'd0);

        // Async reset with three queued LSU entries and x5/x7 pending.
        na = 0;  nl = 0;
        for (int c = 0; c < 5; c++) begin
            logic ar;
            ar = (c % 2 == 0);
            cyc(1'b1, 5'd1, 32'h500 + na, 1'b1, 5'(2 + nl), 32'hB000 + nl,
                (c < 2), (c == 0) ? 5'd5 : 5'd7, ar, 1'b1, !ar);
            if (ar) na++;
            nl++;
        end
        @(negedge clock);
        #2;
        chk("t6_pre_pending", 64'(pending), 64'hA0);
        chk("t6_pre_drain", 64'(exp_q.size()), 64'd0);
        reset = 1'b1;
        #1;
        chk("t6_rst_wen", 64'(rf_wen), 64'd0);
        chk("t6_rst_pending", 64'(pending), 64'd0);
        alu_valid = 0;  lsu_valid = 0;  iss_valid = 0;
        exp_q.delete();
        lsu_model.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("t6_lsu_ready", 64'(lsu_ready), 64'd1);
        repeat (4) idle();
        chk("t6_no_stale", 64'(rf_wen), 64'd0);
        chk("t6_pending", 64'(pending), 64'd0);
        chk("final_drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
